// File: rtl/gray_count_ctrl.sv
// Command-driven Gray-code display counter: prescaler, binary count and registered Gray copy,
// sequenced by an IDLE/RUN/LOAD state machine over a valid/ready command port.
module gray_count_ctrl #(
    parameter int unsigned TICK_DIV = 200_000_000,
    parameter int unsigned CW       = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_cmd_valid,
    output logic          o_cmd_ready,
    input  logic [1:0]    i_cmd,
    input  logic [CW-1:0] i_cmd_data,
    input  logic          i_dir,
    input  logic          i_wrap_en,
    output logic [CW-1:0] o_bin,
    output logic [CW-1:0] o_gray,
    output logic [1:0]    o_state,
    output logic          o_step,
    output logic          o_wrap
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] BIN_MAX   = '1;

    localparam logic [1:0] CMD_START = 2'b00;
    localparam logic [1:0] CMD_STOP  = 2'b01;
    localparam logic [1:0] CMD_LOAD  = 2'b10;
    localparam logic [1:0] CMD_CLEAR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_LOAD = 2'b10
    } state_t;

    state_t        state_q, state_d;
    state_t        ret_q, ret_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [CW-1:0] bin_q, bin_d;
    logic [CW-1:0] gray_q, gray_d;
    logic          step_q, step_d;
    logic          wrap_q, wrap_d;

    logic          cmd_ready;
    logic          accept;
    logic          at_tick;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            ret_q   <= S_IDLE;
            presc_q <= '0;
            bin_q   <= '0;
            gray_q  <= '0;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            presc_q <= presc_d;
            bin_q   <= bin_d;
            gray_q  <= gray_d;
            step_q  <= step_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        presc_d = presc_q;
        bin_d   = bin_q;
        step_d  = 1'b0;
        wrap_d  = 1'b0;
        accept  = i_cmd_valid & cmd_ready;
        at_tick = (state_q == S_RUN) && (presc_q == PRESC_MAX);

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    unique case (i_cmd)
                        CMD_START: begin
                            state_d = S_RUN;
                            presc_d = '0;
                        end
                        CMD_LOAD: begin
                            ret_d   = S_IDLE;
                            state_d = S_LOAD;
                            bin_d   = i_cmd_data;
                            presc_d = '0;
                        end
                        CMD_CLEAR: bin_d = '0;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                // A START while running just lets the prescaler roll on; a tick it hides is lost.
                presc_d = at_tick ? '0 : presc_q + PW'(1);
                if (accept) begin
                    unique case (i_cmd)
                        CMD_STOP: begin
                            state_d = S_IDLE;
                            presc_d = '0;
                        end
                        CMD_LOAD: begin
                            ret_d   = S_RUN;
                            state_d = S_LOAD;
                            bin_d   = i_cmd_data;
                            presc_d = '0;
                        end
                        CMD_CLEAR: begin
                            bin_d   = '0;
                            presc_d = '0;
                        end
                        default: ;
                    endcase
                end else if (at_tick) begin
                    step_d = 1'b1;
                    if (i_dir) begin
                        if (bin_q != BIN_MAX)  bin_d = bin_q + CW'(1);
                        else if (i_wrap_en) begin
                            bin_d  = '0;
                            wrap_d = 1'b1;
                        end else           state_d = S_IDLE;
                    end else begin
                        if (bin_q != '0)       bin_d = bin_q - CW'(1);
                        else if (i_wrap_en) begin
                            bin_d  = BIN_MAX;
                            wrap_d = 1'b1;
                        end else           state_d = S_IDLE;
                    end
                end
            end
            S_LOAD: begin
                state_d = ret_q;
                presc_d = '0;
            end
            default: state_d = S_IDLE;
        endcase

        gray_d = bin_d ^ (bin_d >> 1);
    end

    always_comb begin
        cmd_ready   = (state_q != S_LOAD);
        o_cmd_ready = cmd_ready;
        o_state     = state_q;
        o_bin       = bin_q;
        o_gray      = gray_q;
        o_step      = step_q;
        o_wrap      = wrap_q;
    end

endmodule

// File: tb/tb_gray_count_ctrl.sv
// Directed scenarios plus randomized commands for gray_count_ctrl, checked every cycle
// against a cycle-level behavioural model of the counter.
module tb_gray_count_ctrl;

    localparam int TD = 4;
    localparam int CW = 4;
    localparam int MAXV = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd;
    logic [CW-1:0] cmd_data;
    logic          dir;
    logic          wrap_en;
    logic [CW-1:0] bin;
    logic [CW-1:0] gray;
    logic [1:0]    state;
    logic          step;
    logic          wrap;

    int n_vec = 0;
    int n_err = 0;

    // model: state 0 idle, 1 run, 2 load
    int m_state, m_ret, m_presc, m_bin, m_step, m_wrap;

    gray_count_ctrl #(.TICK_DIV(TD), .CW(CW)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd       (cmd),
        .i_cmd_data  (cmd_data),
        .i_dir       (dir),
        .i_wrap_en   (wrap_en),
        .o_bin       (bin),
        .o_gray      (gray),
        .o_state     (state),
        .o_step      (step),
        .o_wrap      (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_ret = 0; m_presc = 0; m_bin = 0; m_step = 0; m_wrap = 0;
    endtask

    task automatic compare_all();
        int eg;
        eg = m_bin ^ (m_bin >> 1);
        check("bin",   32'(bin),       32'(m_bin));
        check("gray",  32'(gray),      32'(eg));
        check("state", 32'(state),     32'(m_state));
        check("step",  32'(step),      32'(m_step));
        check("wrap",  32'(wrap),      32'(m_wrap));
        check("ready", 32'(cmd_ready), 32'(m_state != 2));
    endtask

    // Advance the model by one clock edge given the inputs presented to it.
    task automatic model_edge(input bit v, input int c, input int d, input bit dr, input bit we);
        bit acc;
        acc = v && (m_state != 2);
        m_step = 0;
        m_wrap = 0;
        if (m_state == 2) begin
            m_state = m_ret;
            m_presc = 0;
        end else if (acc) begin
            case (c)
                0: if (m_state == 0) begin m_state = 1; m_presc = 0; end
                   else m_presc = (m_presc + 1) % TD;
                1: begin m_state = 0; m_presc = 0; end
                2: begin m_ret = m_state; m_state = 2; m_bin = d; m_presc = 0; end
                default: begin m_bin = 0; m_presc = 0; end
            endcase
        end else if (m_state == 1) begin
            if (m_presc == TD - 1) begin
                m_presc = 0;
                m_step  = 1;
                if (dr) begin
                    if (m_bin < MAXV) m_bin = m_bin + 1;
                    else if (we) begin m_bin = 0; m_wrap = 1; end
                    else m_state = 0;
                end else begin
                    if (m_bin > 0) m_bin = m_bin - 1;
                    else if (we) begin m_bin = MAXV; m_wrap = 1; end
                    else m_state = 0;
                end
            end else begin
                m_presc = m_presc + 1;
            end
        end
    endtask

    // One cycle: check outputs settled from the last edge, then present new inputs.
    task automatic apply(input bit v, input int c, input int d, input bit dr, input bit we);
        @(negedge clk);
        compare_all();
        cmd_valid = v;
        cmd       = 2'(c);
        cmd_data  = CW'(d);
        dir       = dr;
        wrap_en   = we;
        if (v && m_state != 2)
            $display("cmd %0d data %0d dir %0d wrap_en %0d from state %0d bin %0d",
                     c, d, dr, we, m_state, m_bin);
        model_edge(v, c, d, dr, we);
    endtask

    task automatic async_reset_pulse();
        #2;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        #1;
        model_reset();
        check("arst_bin",   32'(bin),       32'd0);
        check("arst_gray",  32'(gray),      32'd0);
        check("arst_state", 32'(state),     32'd0);
        check("arst_ready", 32'(cmd_ready), 32'd1);
        $display("async reset asserted between edges");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit r_dir, r_wrap;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd = 2'b00; cmd_data = '0; dir = 1'b1; wrap_en = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        rst_n = 1'b1;

        // count up with wrap through the full range
        apply(1, 0, 0, 1, 1);
        repeat (70) apply(0, 0, 0, 1, 1);

        // saturate at the top, then a START that saturates again
        apply(1, 3, 0, 1, 0);
        repeat (70) apply(0, 0, 0, 1, 0);
        apply(1, 0, 0, 1, 0);
        repeat (8) apply(0, 0, 0, 1, 0);

        // count down from 0 with wrap
        apply(1, 1, 0, 0, 1);
        apply(1, 2, 0, 0, 1);
        apply(0, 0, 0, 0, 1);
        apply(1, 0, 0, 0, 1);
        repeat (12) apply(0, 0, 0, 0, 1);

        // LOAD 10 while running, then count up
        apply(1, 2, 10, 1, 1);
        repeat (10) apply(0, 0, 0, 1, 1);

        // STOP exactly on the tick cycle, then resume
        for (int i = 0; i < 10; i++) begin
            if (m_state == 1 && m_presc == TD - 1) break;
            apply(0, 0, 0, 1, 1);
        end
        check("presc_at_tick", 32'(m_presc == TD - 1), 32'd1);
        apply(1, 1, 0, 1, 1);
        repeat (3) apply(0, 0, 0, 1, 1);
        apply(1, 0, 0, 1, 1);
        repeat (10) apply(0, 0, 0, 1, 1);

        // asynchronous reset mid-run
        async_reset_pulse();
        apply(0, 0, 0, 1, 1);
        apply(1, 0, 0, 1, 1);
        repeat (6) apply(0, 0, 0, 1, 1);

        // randomized commands with occasional direction/wrap flips and resets
        r_dir = 1'b1;
        r_wrap = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            bit v;
            int c;
            if ($urandom_range(31) == 0) r_dir  = ~r_dir;
            if ($urandom_range(31) == 0) r_wrap = ~r_wrap;
            v = ($urandom_range(7) == 0);
            c = $urandom_range(3);
            if (c == 1 && $urandom_range(1) == 0) c = 0;
            apply(v, c, int'($urandom_range(MAXV)), r_dir, r_wrap);
            if ($urandom_range(499) == 0) async_reset_pulse();
        end
        apply(0, 0, 0, 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
